wb_sevenseg: RTL and testbench

WB_SEVENSEG -- requirements
Module: wb_sevenseg

---
 rtl/wb_sevenseg_pkg.sv | 33 +++
 rtl/sevenseg_dec.sv | 30 +++
 rtl/wb_sevenseg.sv | 144 ++++++++++++++
 tb/tb_wb_sevenseg.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_sevenseg_pkg.sv
// Shared register map, reset values and helpers for the Wishbone seven-segment scanner.
package wb_sevenseg_pkg;

  typedef enum logic [1:0] {
    REG_DATA = 2'd0,
    REG_DP   = 2'd1,
    REG_CTRL = 2'd2,
    REG_DIV  = 2'd3
  } reg_sel_e;

  localparam logic [3:0]  ADR_DATA       = 4'h0;
  localparam logic [3:0]  ADR_DP         = 4'h4;
  localparam logic [3:0]  ADR_CTRL       = 4'h8;
  localparam logic [3:0]  ADR_DIV        = 4'hC;

  localparam int          CTRL_BLANK_BIT = 8;
  localparam logic [31:0] DATA_RESET     = 32'h0000_0000;
  localparam logic [7:0]  DP_RESET       = 8'h00;
  localparam logic [8:0]  CTRL_RESET     = 9'h0FF;

  // Replace only the bytes flagged in sel; the caller supplies the current value.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sevenseg_dec.sv
// Hex nibble to active-low seven-segment pattern, bit order {g,f,e,d,c,b,a}.
module sevenseg_dec (
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'h7F;
    case (hex_i)
      4'h0: seg_o = 7'h40;
      4'h1: seg_o = 7'h79;
      4'h2: seg_o = 7'h24;
      4'h3: seg_o = 7'h30;
      4'h4: seg_o = 7'h19;
      4'h5: seg_o = 7'h12;
      4'h6: seg_o = 7'h02;
      4'h7: seg_o = 7'h78;
      4'h8: seg_o = 7'h00;
      4'h9: seg_o = 7'h10;
      4'hA: seg_o = 7'h08;
      4'hB: seg_o = 7'h03;
      4'hC: seg_o = 7'h46;
      4'hD: seg_o = 7'h21;
      4'hE: seg_o = 7'h06;
      4'hF: seg_o = 7'h0E;
      default: seg_o = 7'h7F;
    endcase
  end

endmodule

// File: rtl/wb_sevenseg.sv
// Wishbone slave driving an 8-digit multiplexed seven-segment display.
// Register file plus a down-counting prescaler that steps the scanned digit.
module wb_sevenseg
  import wb_sevenseg_pkg::*;
#(
  parameter logic [15:0] DIV_RESET = 16'd12500
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [3:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic [2:0]  wb_cti_i,
  input  logic [1:0]  wb_bte_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        wb_rty_o,
  output logic [6:0]  seg_o,
  output logic        dp_o,
  output logic [7:0]  an_o
);

  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic [31:0] data_q, data_d;
  logic [7:0]  dp_q, dp_d;
  logic [8:0]  ctrl_q, ctrl_d;
  logic [15:0] div_q, div_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dpo_q, dpo_d;

  reg_sel_e    reg_sel;
  logic        access;
  logic [31:0] rd_val;
  logic [31:0] wr_val;
  logic        adv;
  logic [7:0]  dig_en;
  logic [3:0]  nibble;
  logic [6:0]  seg_dec;
  logic        unused_ok;

  assign unused_ok = ^{wb_adr_i[1:0], wb_cti_i, wb_bte_i};

  assign reg_sel = reg_sel_e'(wb_adr_i[3:2]);
  assign access  = wb_cyc_i & wb_stb_i & ~ack_q;
  assign adv     = (cnt_q == 16'd0);
  assign dig_en  = ctrl_q[7:0];
  assign nibble  = data_q[{idx_q, 2'b00} +: 4];

  sevenseg_dec u_dec (
    .hex_i (nibble),
    .seg_o (seg_dec)
  );

  always_comb begin
    rd_val = 32'h0;
    case (reg_sel)
      REG_DATA: rd_val = data_q;
      REG_DP:   rd_val = {24'h0, dp_q};
      REG_CTRL: rd_val = {23'h0, ctrl_q};
      REG_DIV:  rd_val = {16'h0, div_q};
      default:  rd_val = 32'h0;
    endcase
  end

  // Unused bits of rd_val are zero, so truncating the merge drops writes to them.
  assign wr_val = byte_merge(rd_val, wb_dat_i, wb_sel_i);

  always_comb begin
    ack_d  = access;
    dat_d  = access ? rd_val : 32'h0;
    data_d = data_q;
    dp_d   = dp_q;
    ctrl_d = ctrl_q;
    div_d  = div_q;
    if (access && wb_we_i) begin
      case (reg_sel)
        REG_DATA: data_d = wr_val;
        REG_DP:   dp_d   = wr_val[7:0];
        REG_CTRL: ctrl_d = wr_val[8:0];
        REG_DIV:  div_d  = wr_val[15:0];
        default:  ;
      endcase
    end
  end

  // Outputs come from the pre-edge index and registers, giving the dead-time slot on advance.
  always_comb begin
    cnt_d = cnt_q - 16'd1;
    idx_d = idx_q;
    if (adv) begin
      cnt_d = div_q;
      idx_d = idx_q + 3'd1;
    end
    if (adv || !dig_en[idx_q] || ctrl_q[CTRL_BLANK_BIT]) an_d = 8'hFF;
    else                                                  an_d = ~(8'b1 << idx_q);
    seg_d = seg_dec;
    dpo_d = ~dp_q[idx_q];
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q  <= 1'b0;
      dat_q  <= 32'h0;
      data_q <= DATA_RESET;
      dp_q   <= DP_RESET;
      ctrl_q <= CTRL_RESET;
      div_q  <= DIV_RESET;
      cnt_q  <= DIV_RESET;
      idx_q  <= 3'd0;
      an_q   <= 8'hFF;
      seg_q  <= 7'h7F;
      dpo_q  <= 1'b1;
    end else begin
      ack_q  <= ack_d;
      dat_q  <= dat_d;
      data_q <= data_d;
      dp_q   <= dp_d;
      ctrl_q <= ctrl_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dpo_q  <= dpo_d;
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign wb_err_o = 1'b0;
  assign wb_rty_o = 1'b0;
  assign an_o     = an_q;
  assign seg_o    = seg_q;
  assign dp_o     = dpo_q;

endmodule

// File: tb/tb_wb_sevenseg.sv
// Directed bench for wb_sevenseg: register access, scan timing, blanking and reset behaviour.
module tb_wb_sevenseg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  adr = 4'h0;
  logic [31:0] wdat = 32'h0;
  logic [3:0]  sel = 4'h0;
  logic        we = 1'b0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic [2:0]  cti = 3'h0;
  logic [1:0]  bte = 2'h0;
  logic [31:0] dat_o;
  logic        ack, err, rty;
  logic [6:0]  seg;
  logic        dp;
  logic [7:0]  an;

  int n_cmp = 0;
  int n_bad = 0;

  // Hand-derived active-low patterns for digits 0..7.
  logic [6:0] dec_tab [8] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};

  always #5 clk = ~clk;

  wb_sevenseg #(.DIV_RESET(16'd20)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wb_adr_i (adr),
    .wb_dat_i (wdat),
    .wb_sel_i (sel),
    .wb_we_i  (we),
    .wb_cyc_i (cyc),
    .wb_stb_i (stb),
    .wb_cti_i (cti),
    .wb_bte_i (bte),
    .wb_dat_o (dat_o),
    .wb_ack_o (ack),
    .wb_err_o (err),
    .wb_rty_o (rty),
    .seg_o    (seg),
    .dp_o     (dp),
    .an_o     (an)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_xfer(input logic w, input logic [3:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] r);
    logic got;
    step();
    adr = a; wdat = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
    got = 1'b0;
    r = 32'hDEAD_BEEF;
    for (int i = 0; i < 8 && !got; i++) begin
      step();
      if (ack) begin
        got = 1'b1;
        r = dat_o;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    if (!got) chk("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic wb_wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    wb_xfer(1'b1, a, d, s, r);
  endtask

  task automatic wb_rd(input logic [3:0] a, output logic [31:0] r);
    wb_xfer(1'b0, a, 32'h0, 4'h0, r);
  endtask

  function automatic int seg_to_idx(input logic [6:0] s);
    int res;
    res = -1;
    for (int k = 0; k < 8; k++) if (dec_tab[k] == s) res = k;
    return res;
  endfunction

  initial begin
    logic [31:0] r;
    int          seg_cnt, an_cnt, errs, prev, cur, found;
    logic        seen0, seen2, acked;
    logic [5:0]  ack_pat;

    // Reset values while reset is held
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", {31'h0, ack}, 32'd0);
    chk("rst_dat", dat_o, 32'h0);
    chk("rst_an", {24'h0, an}, 32'hFF);
    chk("rst_seg", {25'h0, seg}, 32'h7F);
    chk("rst_dp", {31'h0, dp}, 32'd1);
    chk("err_rty", {30'h0, err, rty}, 32'd0);

    rst = 1'b0;
    #1;
    chk("an_after_release", {24'h0, an}, 32'hFF);
    step();
    chk("an_first_digit", {24'h0, an}, 32'hFE);
    chk("seg_first_digit", {25'h0, seg}, 32'h40);

    wb_rd(4'h8, r); chk("rd_ctrl_reset", r, 32'h0000_00FF);
    wb_rd(4'h0, r); chk("rd_data_reset", r, 32'h0);
    wb_rd(4'hC, r); chk("rd_div_reset", r, 32'd20);
    wb_rd(4'h4, r); chk("rd_dp_reset", r, 32'h0);

    // Unused bits ignored on write, read as zero
    wb_wr(4'h4, 32'hFFFF_FFFF, 4'hF);
    wb_rd(4'h4, r); chk("dp_unused_bits", r, 32'h0000_00FF);
    wb_wr(4'h8, 32'hFFFF_FFFF, 4'hF);
    wb_rd(4'h8, r); chk("ctrl_unused_bits", r, 32'h0000_01FF);
    wb_wr(4'h8, 32'h0000_00FF, 4'h3);
    wb_rd(4'h8, r); chk("ctrl_restore", r, 32'h0000_00FF);

    // Byte-select write
    wb_wr(4'h0, 32'h7654_3210, 4'b0011);
    wb_rd(4'h0, r); chk("data_sel_lo", r, 32'h0000_3210);

    // DIV=3: digit 2 holds its pattern for DIV+1 cycles
    wb_wr(4'h4, 32'h0000_0004, 4'h1);
    wb_wr(4'hC, 32'h0000_0003, 4'hF);
    found = 0;
    for (int i = 0; i < 400 && found == 0; i++) begin
      step();
      if (an == 8'hFD) found = 1;
    end
    for (int i = 0; i < 40 && found == 1; i++) begin
      step();
      if (an == 8'hFB) found = 2;
    end
    chk("found_digit2", found, 2);
    seg_cnt = 0; an_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (seg != 7'h24) break;
      if (i == 0) chk("dp_on_digit2", {31'h0, dp}, 32'd0);
      seg_cnt++;
      if (an == 8'hFB) an_cnt++;
      step();
    end
    chk("digit2_seg_cycles", seg_cnt, 4);
    chk("digit2_an_cycles", an_cnt, 3);
    chk("digit3_an", {24'h0, an}, 32'hF7);
    chk("digit3_seg", {25'h0, seg}, 32'h30);
    chk("digit3_dp_off", {31'h0, dp}, 32'd1);

    // DIV=0: index advances every cycle, anodes always dark
    wb_wr(4'h0, 32'h7654_3210, 4'hF);
    wb_wr(4'hC, 32'h0, 4'hF);
    repeat (6) step();
    errs = 0;
    prev = seg_to_idx(seg);
    if (prev < 0) errs++;
    for (int i = 0; i < 16; i++) begin
      step();
      cur = seg_to_idx(seg);
      if (prev >= 0 && cur != (prev + 1) % 8) errs++;
      if (an != 8'hFF) errs++;
      prev = cur;
    end
    chk("div0_every_cycle", errs, 0);

    // Global blank, then partial digit enable
    wb_wr(4'hC, 32'h2, 4'hF);
    wb_wr(4'h8, 32'h0000_01FF, 4'hF);
    repeat (4) step();
    errs = 0;
    for (int i = 0; i < 48; i++) begin
      step();
      if (an != 8'hFF) errs++;
    end
    chk("blank_all_dark", errs, 0);

    wb_wr(4'h8, 32'h0000_0005, 4'hF);
    repeat (4) step();
    errs = 0; seen0 = 1'b0; seen2 = 1'b0;
    for (int i = 0; i < 48; i++) begin
      step();
      if (((~an) & 8'hFA) != 8'h00) errs++;
      if ($countones(~an) > 1) errs++;
      if (!an[0]) seen0 = 1'b1;
      if (!an[2]) seen2 = 1'b1;
    end
    chk("en5_only_0_2", errs, 0);
    chk("en5_seen0", {31'h0, seen0}, 32'd1);
    chk("en5_seen2", {31'h0, seen2}, 32'd1);

    // Held strobe: ack toggles every other cycle
    step();
    adr = 4'h0; we = 1'b0; sel = 4'h0; cyc = 1'b1; stb = 1'b1;
    ack_pat = {5'h0, ack};
    for (int i = 0; i < 5; i++) begin
      step();
      ack_pat = {ack_pat[4:0], ack};
    end
    cyc = 1'b0; stb = 1'b0;
    chk("ack_pattern", {26'h0, ack_pat}, 32'b010101);

    // Reset in the middle of a write strobe
    step();
    adr = 4'h4; wdat = 32'h0000_00FF; sel = 4'hF; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    #3 rst = 1'b1;
    acked = ack;
    repeat (2) begin
      step();
      if (ack) acked = 1'b1;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    rst = 1'b0;
    chk("rst_mid_no_ack", {31'h0, acked}, 32'd0);
    wb_rd(4'h4, r); chk("rst_mid_dp", r, 32'h0);
    wb_rd(4'h8, r); chk("rst_mid_ctrl", r, 32'h0000_00FF);
    wb_rd(4'hC, r); chk("rst_mid_div", r, 32'd20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
